corr_pkt_reader: RTL
====================

# corr_pkt_reader

Byte-stream consumer for the correlator packet FIFO. It pops bytes from the show-ahead packet FIFO and reassembles each 5-byte window packet: window number, then countX, countY, countIsect and countSymdiff. Each completed packet is presented as one record on a valid/ready interface. It also checks window-number continuity so that dropped windows are detected and counted. It sits between the correlator's FIFO read port and the host-side record sink (USB/UART bridge or logging logic).

## Interface
- DROP_COUNT_W, 16, width of the saturating dropped-window counter.
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_cg  input  1  clock-gate enable; when low, no state changes and o_pktfifo_pop=0.
- i_pktfifo_data  input  8  FIFO head byte; valid whenever i_pktfifo_empty=0.
- i_pktfifo_empty  input  1  FIFO empty (inverse of valid).
- o_pktfifo_pop  output  1  pop strobe (ready) for the FIFO head byte.
- i_flush  input  1  abandon any partial packet and drop sequence sync; pulse it together with the FIFO flush.
- o_rec_valid  output  1  record available.
- i_rec_ready  input  1  sink accepts the record.
- o_rec_winNum  output  8  window number (byte 0).
- o_rec_pkt  output  32  packet payload, {symdiff, isect, y, x}; byte 1 maps to [7:0] and byte 4 to [31:24].
- o_seqErr  output  1  one-cycle pulse on the cycle a discontinuous record is loaded.
- o_dropCount  output  DROP_COUNT_W  saturating total of windows missed.
- o_synced  output  1  an expected window number is held.

## Operation
- Byte index register idx runs 0..4.
  - idx=0: pop loads the winNum holding register.
  - idx=1..4: pop loads payload byte idx-1.
  - Index increments on each pop and wraps 4->0.
- Pop condition: i_cg && !i_pktfifo_empty && !i_flush && (idx!=4 || !o_rec_valid || i_rec_ready).
  - The final byte is not popped while the output register is occupied and not being drained.
  - Bytes at idx 0..3 are always consumed, so a stalled sink does not block byte collection.
- Record load: on the idx=4 pop, o_rec_winNum/o_rec_pkt load the holding registers plus the current byte, and o_rec_valid is set.
- Record handshake: the record is accepted on o_rec_valid && i_rec_ready. Valid clears unless a new load happens in the same cycle; load takes priority, giving back-to-back records.
- Sequence check on each load:
  - !o_synced: set expected = winNum+1 and o_synced=1. No error.
  - synced and winNum==expected: no error. expected = winNum+1.
  - synced and winNum!=expected: pulse o_seqErr, o_dropCount += (winNum-expected) mod 256, saturating at all-ones. expected = winNum+1.
  - winNum arithmetic is mod 256 (255->0 is continuous).
- Flush:
  - Sets idx=0 and o_synced=0.
  - o_rec_valid/o_rec_* and o_dropCount are unchanged.
  - A pending record remains deliverable.
  - If flush coincides with a would-be pop, no pop occurs.
- Reset: every output is 0, idx=0, expected=0, holding registers 0.

## Timing
- o_pktfifo_pop is combinational from inputs and state. i_pktfifo_data is sampled on the same edge as the pop.
- Latency: o_rec_valid is asserted the cycle after the 5th byte's pop.
- Throughput: 1 byte/cycle, so one record per 5 cycles with no bubbles when the FIFO stays non-empty and i_rec_ready=1.
- o_seqErr and the o_dropCount update are registered with the record load and visible together with the new o_rec_valid.
- Asserting reset mid-packet discards the partial packet immediately. After reset, the first byte read is treated as a winNum.

## Configuration
- CORR_PKT_READER_SEQCHECK_EN:
  - Defined: sequence checking as above.
  - Undefined: the expected register, comparator and counter are removed. o_seqErr=0, o_dropCount=0 and o_synced=0 constantly. Record assembly is unchanged.

## Structure
- Package corr_pkt_pkg holds:
  - PKT_BYTES=5.
  - Byte-index typedef (3 bits).
  - Byte offset constants: BYTE_WINNUM=0, BYTE_X=1, BYTE_Y=2, BYTE_ISECT=3, BYTE_SYMDIFF=4.
  - The correlator's packetizer shares this package.
- Sub-module corr_seq_check:
  - Inputs: load strobe, winNum, flush.
  - Outputs: seqErr, dropCount, synced.
  - Instantiated only under CORR_PKT_READER_SEQCHECK_EN.

## Test plan
- Reset, then feed bytes 00,11,22,33,44 with i_rec_ready=1 -> one record: winNum=00, pkt=32'h44332211, o_synced=1, o_seqErr=0; o_rec_valid high exactly one cycle.
- Feed packets winNum 05 then 09 -> o_seqErr pulses on the second record, o_dropCount=3; then winNum FF followed by 00 -> no error.
- Hold i_rec_ready=0 while two full packets are queued -> first record held stable; 4 bytes of the second popped; pop stalls at idx=4; raising ready yields the second record the next cycle.
- Pulse i_flush after 2 bytes, then feed 07,A,B,C,D -> record winNum=07, pkt={D,C,B,A}, o_seqErr=0 (resynced).
- Drive i_cg=0 with a non-empty FIFO -> o_pktfifo_pop=0 and no state change; the packet completes normally once i_cg=1.
- Force dropCount near saturation (gap of 200 twice with DROP_COUNT_W=8) -> o_dropCount saturates at FF.

Source files
------------

// File: rtl/corr_pkt_pkg.sv
// Shared definitions for the correlator packet format.
// The packetizer that writes the FIFO and the reader that consumes it both use these.
package corr_pkt_pkg;

  localparam int PKT_BYTES = 5;

  typedef logic [2:0]  byte_idx_t;
  typedef logic [7:0]  win_num_t;
  typedef logic [31:0] pkt_payload_t;

  // Byte order inside one window packet
  localparam byte_idx_t BYTE_WINNUM  = 3'd0;
  localparam byte_idx_t BYTE_X       = 3'd1;
  localparam byte_idx_t BYTE_Y       = 3'd2;
  localparam byte_idx_t BYTE_ISECT   = 3'd3;
  localparam byte_idx_t BYTE_SYMDIFF = byte_idx_t'(PKT_BYTES - 1);

  // Advance the byte index, wrapping after the last byte of a packet
  function automatic byte_idx_t next_idx(input byte_idx_t idx);
    return (idx == BYTE_SYMDIFF) ? BYTE_WINNUM : idx + 3'd1;
  endfunction

endpackage

// File: rtl/corr_pkt_reader_if.sv
// Record handshake between the packet reader (master) and the host-side sink (slave).
interface corr_pkt_reader_if;
  import corr_pkt_pkg::*;

  logic         valid;
  logic         ready;
  win_num_t     win_num;
  pkt_payload_t pkt;

  modport master (output valid, output win_num, output pkt, input ready);
  modport slave  (input valid, input win_num, input pkt, output ready);

endinterface

// File: rtl/corr_seq_check.sv
// Window-number continuity checker: tracks the expected next window and
// accumulates a saturating count of windows that went missing.
module corr_seq_check
  import corr_pkt_pkg::*;
#(
  parameter int DROP_COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cg,
  input  logic                    load,
  input  logic                    flush,
  input  win_num_t                win_num,
  output logic                    seq_err,
  output logic [DROP_COUNT_W-1:0] drop_count,
  output logic                    synced
);

  win_num_t expected;
  win_num_t gap;

  // Add an 8-bit gap to the counter, clamping at all-ones
  function automatic logic [DROP_COUNT_W-1:0] sat_add(input logic [DROP_COUNT_W-1:0] a,
                                                      input win_num_t b);
    logic [DROP_COUNT_W:0] sum;
    sum = {1'b0, a} + (DROP_COUNT_W+1)'(b);
    return sum[DROP_COUNT_W] ? {DROP_COUNT_W{1'b1}} : sum[DROP_COUNT_W-1:0];
  endfunction

  // Windows skipped between the expected and the received number (mod 256)
  assign gap = win_num - expected;

  // Update sync state, error pulse and drop counter on each record load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err    <= 1'b0;
      drop_count <= '0;
      synced     <= 1'b0;
      expected   <= '0;
    end else if (cg) begin
      seq_err <= 1'b0;
      if (load) begin
        expected <= win_num + 8'd1;
        synced   <= 1'b1;
        if (synced && gap != 8'd0) begin
          seq_err    <= 1'b1;
          drop_count <= sat_add(drop_count, gap);
        end
      end else if (flush) begin
        synced <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/corr_pkt_reader.sv
// Correlator packet FIFO reader: pops bytes from the show-ahead FIFO,
// reassembles 5-byte window packets and presents them as records.
// Optional window continuity checking is built when CORR_PKT_READER_SEQCHECK_EN is defined.
module corr_pkt_reader
  import corr_pkt_pkg::*;
#(
  parameter int DROP_COUNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cg,
  input  logic [7:0]              i_pktfifo_data,
  input  logic                    i_pktfifo_empty,
  output logic                    o_pktfifo_pop,
  input  logic                    i_flush,
  corr_pkt_reader_if.master       rec,
  output logic                    o_seqErr,
  output logic [DROP_COUNT_W-1:0] o_dropCount,
  output logic                    o_synced
);

  byte_idx_t    idx;
  win_num_t     win_hold;
  logic [23:0]  pay_hold;
  logic         rec_valid;
  win_num_t     rec_win;
  pkt_payload_t rec_pkt;
  logic         pop;
  logic         load;

  // Bytes 0..3 always drain; the last byte waits until the output slot is free
  assign pop  = i_cg && !i_pktfifo_empty && !i_flush &&
                (idx != BYTE_SYMDIFF || !rec_valid || rec.ready);
  assign load = pop && (idx == BYTE_SYMDIFF);

  assign o_pktfifo_pop = pop;
  assign rec.valid     = rec_valid;
  assign rec.win_num   = rec_win;
  assign rec.pkt       = rec_pkt;

  // Byte index: advances per pop, flush restarts at the window-number byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx <= BYTE_WINNUM;
    end else if (i_cg && i_flush) begin
      idx <= BYTE_WINNUM;
    end else if (pop) begin
      idx <= next_idx(idx);
    end
  end

  // Holding registers collect the window number and the first three payload bytes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_hold <= '0;
      pay_hold <= '0;
    end else if (pop) begin
      case (idx)
        BYTE_WINNUM: win_hold        <= i_pktfifo_data;
        BYTE_X:      pay_hold[7:0]   <= i_pktfifo_data;
        BYTE_Y:      pay_hold[15:8]  <= i_pktfifo_data;
        BYTE_ISECT:  pay_hold[23:16] <= i_pktfifo_data;
        default:     ;
      endcase
    end
  end

  // Output record: load on the last byte (wins over a same-cycle drain)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_valid <= 1'b0;
      rec_win   <= '0;
      rec_pkt   <= '0;
    end else if (load) begin
      rec_valid <= 1'b1;
      rec_win   <= win_hold;
      rec_pkt   <= {i_pktfifo_data, pay_hold};
    end else if (i_cg && rec_valid && rec.ready) begin
      rec_valid <= 1'b0;
    end
  end

`ifdef CORR_PKT_READER_SEQCHECK_EN
  corr_seq_check #(
    .DROP_COUNT_W (DROP_COUNT_W)
  ) u_seq_check (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .cg         (i_cg),
    .load       (load),
    .flush      (i_flush),
    .win_num    (win_hold),
    .seq_err    (o_seqErr),
    .drop_count (o_dropCount),
    .synced     (o_synced)
  );
`else
  assign o_seqErr    = 1'b0;
  assign o_dropCount = '0;
  assign o_synced    = 1'b0;
`endif

endmodule
